// File: rtl/axi_mem_slave.sv
// axi_mem_slave: single-outstanding memory slave on a shared-address AXI-style bus.
// Unwritten words read as zero; write/read completions are counted with saturation.
module axi_mem_slave #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic              ar_valid,
  output logic              ar_ready,
  input  logic              aw_valid,
  output logic              aw_ready,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic              b_valid,
  input  logic              b_ready,
  output logic [CNT_W-1:0]  wr_count,
  output logic [CNT_W-1:0]  rd_count
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_DATA = 2'd1,
    WR_RESP = 2'd2,
    RD_DATA = 2'd3
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
  logic [DEPTH-1:0]    written_q, written_d;
  logic                idle_q, idle_d;
  logic                wr_phase_q, wr_phase_d;
  logic                b_valid_q, b_valid_d;
  logic                r_valid_q, r_valid_d;
  logic                mem_we_s;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  // Next-state, datapath and per-state output flag computation
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rdata_d    = rdata_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    written_d  = written_q;
    mem_we_s   = 1'b0;
    case (state_q)
      IDLE: begin
        // aw_ready is always high here, so aw_valid alone is the AW handshake
        if (aw_valid) begin
          addr_d  = mem_addr;
          state_d = WR_DATA;
        end else if (ar_valid) begin
          addr_d  = mem_addr;
          rdata_d = written_q[mem_addr] ? mem_q[mem_addr] : {DATA_W{1'b0}};
          state_d = RD_DATA;
        end else begin
          state_d = IDLE;
        end
      end
      WR_DATA: begin
        if (wdata_valid) begin
          mem_we_s          = 1'b1;
          written_d[addr_q] = 1'b1;
          state_d           = WR_RESP;
        end else begin
          state_d = WR_DATA;
        end
      end
      WR_RESP: begin
        if (b_ready) begin
          wr_cnt_d = sat_inc(wr_cnt_q);
          state_d  = IDLE;
        end else begin
          state_d = WR_RESP;
        end
      end
      RD_DATA: begin
        if (rdata_ready) begin
          rd_cnt_d = sat_inc(rd_cnt_q);
          state_d  = IDLE;
        end else begin
          state_d = RD_DATA;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    idle_d     = (state_d == IDLE);
    wr_phase_d = (state_d == WR_DATA);
    b_valid_d  = (state_d == WR_RESP);
    r_valid_d  = (state_d == RD_DATA);
  end

  // Control and status registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= {ADDR_W{1'b0}};
      rdata_q    <= {DATA_W{1'b0}};
      wr_cnt_q   <= {CNT_W{1'b0}};
      rd_cnt_q   <= {CNT_W{1'b0}};
      written_q  <= {DEPTH{1'b0}};
      idle_q     <= 1'b1;
      wr_phase_q <= 1'b0;
      b_valid_q  <= 1'b0;
      r_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rdata_q    <= rdata_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      written_q  <= written_d;
      idle_q     <= idle_d;
      wr_phase_q <= wr_phase_d;
      b_valid_q  <= b_valid_d;
      r_valid_q  <= r_valid_d;
    end
  end

  // Storage array; validity is tracked by the bitmap, so no reset is needed
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[addr_q] <= mem_data_i;
    end
  end

  assign aw_ready    = idle_q & ~reset;
  assign ar_ready    = idle_q & ~aw_valid & ~reset;
  assign wdata_ready = wr_phase_q & ~reset;
  assign b_valid     = b_valid_q;
  assign rdata_valid = r_valid_q;
  assign mem_data_o  = rdata_q;
  assign wr_count    = wr_cnt_q;
  assign rd_count    = rd_cnt_q;

endmodule

// File: doc/axi_mem_slave.md
Name: axi_mem_slave

Overview:
- Memory-backed slave that consumes the master-side AXI-style bus: shared 7-bit address, 32-bit data, and AR/AW/W/R/B valid-ready pairs.
- Sits directly downstream of the bus master driver and is the target of every transaction it issues.
- Holds a DEPTH x DATA_W word array and completes one transaction at a time.
- Exposes saturating transaction counters for scoreboard cross-checks.

Parameters:
ADDR_W, 7, address width; DEPTH = 2**ADDR_W words
DATA_W, 32, data word width
CNT_W, 16, width of the write/read completion counters

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
mem_addr  input  ADDR_W  transaction word address, sampled on AW or AR handshake
mem_data_i  input  DATA_W  write data from master, sampled on W handshake
mem_data_o  output  DATA_W  read data to master, valid while rdata_valid=1
ar_valid  input  1  read address valid
ar_ready  output  1  read address accepted
aw_valid  input  1  write address valid
aw_ready  output  1  write address accepted
wdata_valid  input  1  write data valid
wdata_ready  output  1  write data accepted
rdata_valid  output  1  read data valid
rdata_ready  input  1  master accepts read data
b_valid  output  1  write response valid
b_ready  input  1  master accepts write response
wr_count  output  CNT_W  completed writes (B handshakes), saturating
rd_count  output  CNT_W  completed reads (R handshakes), saturating

Behaviour:
- Reset asserted (asynchronous):
  - State goes to IDLE.
  - All ready and valid outputs are 0. Ready outputs are gated by reset.
  - mem_data_o=0, wr_count=0, rd_count=0.
  - Written-bitmap (DEPTH bits) cleared. Array contents are not reset.
- Handshake rule: a handshake occurs on a rising clk edge where valid=1 and ready=1. The slave never waits on the master's valid before raising its own ready.
- FSM states: IDLE, WR_DATA, WR_RESP, RD_DATA.
- IDLE:
  - aw_ready=1.
  - ar_ready = ~aw_valid, so writes win when AW and AR are valid together.
  - AW handshake: latch mem_addr into addr_q, go to WR_DATA.
  - Else AR handshake: latch addr, register mem_data_o, go to RD_DATA. mem_data_o = bitmap[addr] ? mem[addr] : 0.
- WR_DATA:
  - wdata_ready=1.
  - On wdata_valid: write mem[addr_q] <= mem_data_i, set bitmap[addr_q], go to WR_RESP.
- WR_RESP:
  - b_valid=1, held until b_ready.
  - On b_ready: wr_count++ (saturates at all-ones), go to IDLE.
- RD_DATA:
  - rdata_valid=1. mem_data_o is held stable until the handshake.
  - On rdata_ready: rd_count++ (saturating), go to IDLE. mem_data_o is held at its last value afterwards.
- Latency:
  - Write, AW handshake at edge N: wdata_ready=1 from N+1. A W handshake at edge M gives b_valid=1 from M+1.
  - Read, AR handshake at edge N: rdata_valid=1 with data from N+1.
  - Back-to-back transactions: the minimum gap is one cycle in IDLE.
- Read-after-write to the same address returns the new data, because the array write happens before WR_RESP.
- Address wrap: none. mem_addr is full ADDR_W width, so every address is legal.
- Inputs outside the current phase (for example wdata_valid in IDLE, rdata_ready in WR_RESP) are ignored. No state change, no error.
- Reset mid-transaction: the transaction is abandoned and no response is produced. A partial write is not committed unless the W handshake edge preceded reset. Counters and bitmap clear.
- Counter saturation: at 2**CNT_W-1 the counter holds. It never wraps to 0.

Test Plan:
- Single write/read: AW addr=7'h05, W data=32'hA5A5_1234, b_ready=1, then AR addr=7'h05 with rdata_ready=1. Required: b_valid 1 cycle after the W handshake; rdata_valid 1 cycle after AR with mem_data_o=32'hA5A5_1234; wr_count=1, rd_count=1.
- Unwritten read: after reset, AR addr=7'h7F. Required: mem_data_o=32'h0000_0000; rd_count=1.
- Simultaneous AW/AR in IDLE: addr=7'h10, ar_valid=aw_valid=1. Required: ar_ready=0 and aw_ready=1 that cycle; write proceeds first; AR is accepted only after return to IDLE.
- Backpressure: hold b_ready=0 for 5 cycles, then hold rdata_ready=0 for 5 cycles. Required: b_valid and rdata_valid stay 1; mem_data_o stays stable; counters increment only on the handshake edge.
- Reset mid-write: AW handshake addr=7'h22, assert reset in WR_DATA before wdata_valid, then read 7'h22. Required: all outputs 0 during reset; read returns 0; wr_count=0.
- Saturation (CNT_W=2): perform 5 writes. Required: wr_count sequence 1,2,3,3,3.
